// File: rtl/if_fetch.sv
// if_fetch: MIPS IF stage owning the PC, imem req/ready handshake, redirects and a one-entry stall skid buffer
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc_4,
  output logic [31:0] IF_inst,
  output logic        addr_err
);
  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, pend_pc, pend_pc_n, buf_inst, buf_inst_n, buf_pc4, buf_pc4_n;
  logic        outst, outst_n;
  logic [31:0] tgt, pc_4;
  logic        acc;
  assign tgt       = {redirect_pc[31:2], 2'b00};
  assign pc_4      = pc + 32'd4;
  assign imem_req  = state == FETCH ? (!stall | outst) : state == DRAIN;
  assign imem_addr = pc;
  assign acc       = imem_req & imem_ready;
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    outst_n    = outst;
    pend_pc_n  = pend_pc;
    buf_inst_n = buf_inst;
    buf_pc4_n  = buf_pc4;
    IF_inst    = NOP;
    IF_pc_4    = pc_4;
    case (state)
      FETCH:
        if (redirect) begin
          if (acc || !imem_req) begin
            pc_n    = tgt;
            outst_n = 1'b0;
          end else begin
            pend_pc_n = tgt;
            state_n   = DRAIN;
          end
        end else if (acc) begin
          pc_n    = pc_4;
          outst_n = 1'b0;
          if (stall) begin
            buf_inst_n = imem_rdata;
            buf_pc4_n  = pc_4;
            state_n    = HOLD;
          end else
            IF_inst = imem_rdata;
        end else if (imem_req)
          outst_n = 1'b1;
      DRAIN: begin
        if (redirect) pend_pc_n = tgt;
        if (acc) begin
          pc_n    = redirect ? tgt : pend_pc;
          outst_n = 1'b0;
          state_n = FETCH;
        end
      end
      HOLD:
        if (redirect) begin
          pc_n    = tgt;
          state_n = FETCH;
        end else begin
          IF_inst = buf_inst;
          IF_pc_4 = buf_pc4;
          if (!stall) state_n = FETCH;
        end
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      outst    <= 1'b0;
      pend_pc  <= 32'h0;
      buf_inst <= NOP;
      buf_pc4  <= RESET_PC + 32'd4;
      addr_err <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      outst    <= outst_n;
      pend_pc  <= pend_pc_n;
      buf_inst <= buf_inst_n;
      buf_pc4  <= buf_pc4_n;
      addr_err <= redirect & |redirect_pc[1:0];
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed + random stimulus for if_fetch, checked each cycle against a transaction-level model
module tb_if_fetch;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0, imem_ready = 1'b1;
  logic [31:0] redirect_pc = 32'h0, imem_rdata, imem_addr, IF_pc_4, IF_inst;
  logic        imem_req, addr_err;
  logic [31:0] rmask = 32'h0;
  int          checks = 0, errors = 0;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_pc_4(IF_pc_4), .IF_inst(IF_inst), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  // memory word at address a is a ^ rmask
  assign imem_rdata = imem_addr ^ rmask;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  typedef struct {logic [31:0] inst; logic [31:0] pc4;} ent_t;
  ent_t        held[$];
  logic [31:0] m_pc, m_tgt, e_inst, e_pc4, tg;
  logic        m_busy, m_stale, m_aerr, e_req, e_acc;

  // model: next fetch address, whether a request is already committed, whether the
  // in-flight word is stale (with its replacement target), and a queue of held words
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_busy = 1'b0; m_stale = 1'b0; m_aerr = 1'b0;
      held.delete();
    end
    tg    = {redirect_pc[31:2], 2'b00};
    e_req = held.size() != 0 ? 1'b0 : (m_stale | m_busy | !stall);
    e_acc = e_req & imem_ready;
    e_inst = 32'h0;
    e_pc4  = m_pc + 32'd4;
    if (held.size() != 0 && !redirect) begin
      e_inst = held[0].inst;
      e_pc4  = held[0].pc4;
    end else if (held.size() == 0 && !m_stale && !redirect && e_acc && !stall)
      e_inst = m_pc ^ rmask;
    chk("req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("addr", imem_addr, m_pc);
    chk("inst", IF_inst, e_inst);
    chk("pc4", IF_pc_4, e_pc4);
    chk("addr_err", {31'b0, addr_err}, {31'b0, m_aerr});
    if (rst_n) begin
      m_aerr = redirect && redirect_pc[1:0] != 2'b00;
      if (held.size() != 0) begin
        if (redirect) begin held.delete(); m_pc = tg; end
        else if (!stall) held.delete();
      end else if (m_stale) begin
        if (redirect) m_tgt = tg;
        if (e_acc) begin m_pc = m_tgt; m_stale = 1'b0; m_busy = 1'b0; end
      end else if (redirect) begin
        if (e_acc || !e_req) begin m_pc = tg; m_busy = 1'b0; end
        else begin m_stale = 1'b1; m_tgt = tg; end
      end else if (e_acc) begin
        if (stall) held.push_back('{inst: m_pc ^ rmask, pc4: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
        m_busy = 1'b0;
      end else if (e_req) m_busy = 1'b1;
    end
  end

  task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
    @(posedge clk); #1;
    stall = s; redirect = r; redirect_pc = rp; imem_ready = rdy;
    @(negedge clk); #1;
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", IF_inst, 32'h0);
    chk("rst_pc4", IF_pc_4, 32'h4);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("s0_addr", imem_addr, 32'h0);
    chk("s0_pc4", IF_pc_4, 32'h4);
    step(0, 0, 0, 1);
    chk("s1_addr", imem_addr, 32'h4);
    chk("s1_inst", IF_inst, 32'h4);
    step(0, 0, 0, 0);
    chk("w0_addr", imem_addr, 32'h8);
    chk("w0_inst", IF_inst, 32'h0);
    step(0, 0, 0, 0);
    chk("w1_req", {31'b0, imem_req}, 32'h1);
    step(0, 0, 0, 1);
    chk("w2_inst", IF_inst, 32'h8);
    chk("w2_pc4", IF_pc_4, 32'hC);
    step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    chk("rd0_addr", imem_addr, 32'hC);
    step(0, 1, 32'h200, 0);
    chk("rd1_addr", imem_addr, 32'hC);
    step(0, 0, 0, 1);
    chk("rd2_inst", IF_inst, 32'h0);
    step(0, 0, 0, 1);
    chk("rd3_addr", imem_addr, 32'h200);
    chk("rd3_inst", IF_inst, 32'h200);
    rmask = 32'hA500_0000;
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("st0_inst", IF_inst, 32'h0);
    step(1, 0, 0, 1);
    chk("st1_req", {31'b0, imem_req}, 32'h0);
    chk("st1_inst", IF_inst, 32'hA500_0204);
    chk("st1_pc4", IF_pc_4, 32'h208);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("st3_inst", IF_inst, 32'hA500_0204);
    step(0, 0, 0, 1);
    chk("st4_addr", imem_addr, 32'h208);
    step(0, 1, 32'h102, 1);
    step(0, 0, 0, 1);
    chk("mis_err", {31'b0, addr_err}, 32'h1);
    chk("mis_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1);
    chk("mis_err_clr", {31'b0, addr_err}, 32'h0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h300, 0);
    step(0, 0, 0, 0);
    chk("dr_addr", imem_addr, 32'h108);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rd_rst_addr", imem_addr, 32'h0);
    chk("rd_rst_inst", IF_inst, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; imem_ready = 1'b1;
    @(negedge clk); #1;
    chk("rd_rel_inst", IF_inst, 32'hA500_0000);
    chk("rd_rel_pc4", IF_pc_4, 32'h4);
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    chk("wrap_pc4", IF_pc_4, 32'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom & 32'h0000_0FFF, $urandom_range(0, 2) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues instruction-memory reads over a req/ready handshake, and drives the `IF_pc_4`/`IF_inst` pair that the IF/ID pipeline register captures.
- Absorbs variable memory latency, hazard-unit stalls and branch/jump redirects.
- Whenever no valid instruction is available, emits a NOP bubble, so the pipeline register never needs a separate valid bit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset; first fetch address.
- `NOP`, default 32'h0000_0000: bubble instruction (`sll $0,$0,0`).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: IF/ID is holding this cycle.
- `redirect`  in  1  taken branch/jump; fetch must restart at `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  read address; word aligned.
- `imem_ready`  in  1  read completes this cycle; `imem_rdata` valid.
- `imem_rdata`  in  32  instruction word.
- `IF_pc_4`  out  32  address of presented instruction + 4.
- `IF_inst`  out  32  presented instruction, or `NOP`.
- `addr_err`  out  1  one-cycle pulse: the previous cycle's redirect target was misaligned.

## Operation
Registers:
- `pc` (32): current fetch address.
- `state`: FETCH, DRAIN or HOLD.
- `outst` (1): a request has been raised and not yet completed.
- `pend_pc` (32): redirect target saved while draining.
- `buf_inst` / `buf_pc4` (32 each): one-entry skid buffer.

Handshake rules:
- Accept = `imem_req & imem_ready`.
- Once `imem_req` is raised, it and `imem_addr` stay constant until accept. A request is never withdrawn.
- Redirect targets are forced aligned: `{redirect_pc[31:2],2'b00}`. A nonzero `redirect_pc[1:0]` sets `addr_err` for the next cycle.

Default outputs, used whenever no row below overrides them: `IF_inst`=`NOP`, `IF_pc_4`=`pc+4`, all arithmetic mod 2^32 (0xFFFF_FFFC wraps to 0).

FETCH state:
- `imem_addr`=`pc`; `imem_req` = `!stall | outst`.
- redirect (any accept state) → `IF_inst`=`NOP`.
  - If accepted, or no request raised: `pc`←target, stay in FETCH, `outst`←0.
  - If a request is pending and not accepted: `pend_pc`←target, go to DRAIN.
- Accept with `!stall` → `IF_inst`=`imem_rdata`, `IF_pc_4`=`pc+4`, `pc`←`pc+4`.
- Accept with `stall` → `buf_inst`←`imem_rdata`, `buf_pc4`←`pc+4`, `pc`←`pc+4`, go to HOLD; outputs stay NOP.
- Request raised, no accept → `outst`←1; `pc` holds.

DRAIN state (a stale request is outstanding):
- `imem_req`=1, `imem_addr`=`pc`; outputs stay NOP.
- redirect → `pend_pc`←new target (latest wins).
- On accept: data discarded, `pc`←`pend_pc` (or the same-cycle redirect target), `outst`←0, go to FETCH.

HOLD state:
- `imem_req`=0; `IF_inst`=`buf_inst`, `IF_pc_4`=`buf_pc4`.
- `!stall` → IF/ID captures the buffer this cycle; go to FETCH.
- redirect → buffer discarded, outputs NOP, `pc`←target, go to FETCH. Redirect wins over stall.

Reset:
- `pc`=`RESET_PC`, `state`=FETCH, `outst`=0, `pend_pc`=0, `buf_inst`=`NOP`, `buf_pc4`=`RESET_PC+4`, `addr_err`=0.
- Any in-flight memory transaction is abandoned; the memory shares `rst_n`.

## Timing
- With `imem_ready` tied high and no stall: one instruction per cycle, zero-cycle fetch latency. `imem_rdata` flows combinationally to `IF_inst` in the accept cycle.
- Each cycle of `imem_ready` low inserts one NOP bubble.
- Redirect: the target address appears on `imem_addr` the cycle after `redirect` in FETCH/HOLD. In DRAIN it appears the cycle after the stale accept.
- `stall` → `imem_req` is a combinational path; `imem_req` depends on `stall` only when `outst`=0.
- `addr_err` is registered: it is high for exactly the cycle after the misaligned redirect.
- All outputs are combinational from registers and current inputs; there are no internal pipeline stages.

## Test plan
- **Streaming:** release reset, `imem_ready`=1, memory returns data = address. Expect `imem_addr` 0x0, 0x4, 0x8 on consecutive cycles, `IF_pc_4` 0x4, 0x8, 0xC, `IF_inst` = 0x0, 0x4, 0x8.
- **Wait states:** drop `imem_ready` for 2 cycles at address 0x8. Expect `imem_req`=1 with `imem_addr`=0x8 held, `IF_inst`=`NOP` for 2 cycles, then 0x8 with `IF_pc_4`=0xC.
- **Redirect during wait:** `imem_ready` low at 0x8; pulse `redirect` with target 0x100, then pulse again with 0x200 before ready. Expect address held at 0x8 until accept, data discarded (NOP), next `imem_addr`=0x200.
- **Stall on accept:** assert `stall` in the accept cycle of 0x4, hold it 3 cycles. Expect `imem_req`=0 during HOLD and `IF_inst`=word(0x4), `IF_pc_4`=0x8 presented throughout. After `stall` drops, next `imem_addr`=0x8.
- **Misaligned redirect:** `redirect_pc`=0x102. Expect `addr_err`=1 for one cycle and next `imem_addr`=0x100.
- **Reset mid-DRAIN:** assert `rst_n` low while in DRAIN. Expect `imem_addr`=`RESET_PC`, `outst`=0, `IF_inst`=`NOP`; fetch resumes at `RESET_PC` after release.
